// File: rtl/uart_rx_loader.sv
// -----------------------------------------------------------------------------
// uart_rx_loader
//
// Serial program/data loader. It deserialises UART bytes from the board rx pin
// and packs them little-endian into 32-bit words. Each word is presented with
// an auto-incrementing byte address and a one-cycle write strobe. After the
// line has been idle for TIMEOUT_CYC cycles, the loader flushes any partial
// word and raises a sticky done flag, which releases the CPU from load mode.
//
// Optional feature macro: UART_PARITY_EN
//   defined   : 8E1 frames, with a PARITY state between DATA and STOP
//   undefined : 8N1 frames only
//
// Ports
//   clk        in   1   cpuclk domain, all logic on posedge
//   rst_n      in   1   asynchronous reset, active-low
//   rx         in   1   UART line, idle high, asynchronous to clk
//   data_out   out  32  packed word, first byte received -> [7:0]
//   addr_out   out  32  byte address of data_out
//   wr_en      out  1   one-cycle strobe, data_out/addr_out valid this cycle
//   done       out  1   sticky load-complete flag
//   frame_err  out  1   sticky flag for a bad stop bit or a parity error
// -----------------------------------------------------------------------------
module uart_rx_loader #(
    parameter int unsigned CLK_HZ      = 25_000_000,
    parameter int unsigned BAUD        = 115_200,
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter int unsigned TIMEOUT_CYC = 2_500_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx,
    output logic [31:0] data_out,
    output logic [31:0] addr_out,
    output logic        wr_en,
    output logic        done,
    output logic        frame_err
);

    localparam int unsigned DIV = CLK_HZ / BAUD;
    localparam int unsigned CW  = $clog2(DIV);
    localparam int unsigned TW  = $clog2(TIMEOUT_CYC + 1);

    localparam logic [CW-1:0] HALF_LOAD = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV - 1);
    localparam logic [TW-1:0] TO_MAX    = TW'(TIMEOUT_CYC);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYC - 1);

`ifdef UART_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t        state_q, state_d;
    logic          rx_meta, rx_s;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic [1:0]    byte_cnt;
    logic [31:0]   word_buf;
    logic [31:0]   next_addr;
    logic          word_written;
    logic [TW-1:0] idle_cnt;
    logic          flush_pend;
    logic          tick;
    logic          stop_tick;
    logic          byte_ok;
    logic          timeout_fire;

    assign tick = (baud_cnt == '0);
    assign stop_tick = (state_q == S_STOP) && tick;

`ifdef UART_PARITY_EN
    logic par_err;
    assign byte_ok = rx_s && !par_err;
`else
    assign byte_ok = rx_s;
`endif

    // Fires once, on the cycle the idle counter reaches TIMEOUT_CYC.
    assign timeout_fire = (state_q == S_IDLE) && rx_s && !done && !flush_pend &&
                          (idle_cnt == TO_LAST);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: next state gets a default first, so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (!done && !rx_s) state_d = S_START;
            S_START:  if (tick) state_d = rx_s ? S_IDLE : S_DATA;
`ifdef UART_PARITY_EN
            S_DATA:   if (tick && bit_cnt == 3'd7) state_d = S_PARITY;
            S_PARITY: if (tick) state_d = S_STOP;
`else
            S_DATA:   if (tick && bit_cnt == 3'd7) state_d = S_STOP;
`endif
            S_STOP:   if (tick) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Two-flop synchroniser, reset to the idle line level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // Bit timing and deserialisation. The counter sits at the half-bit load
    // value while idle, so START samples mid start bit, and then every full
    // bit period after that lands mid-bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_cnt <= HALF_LOAD;
            bit_cnt  <= '0;
            shift    <= '0;
`ifdef UART_PARITY_EN
            par_err  <= 1'b0;
`endif
        end else begin
            if (state_q == S_IDLE) begin
                baud_cnt <= HALF_LOAD;
            end else if (tick) begin
                baud_cnt <= DIV_LOAD;
            end else begin
                baud_cnt <= baud_cnt - CW'(1);
            end

            if (state_q == S_START) begin
                bit_cnt <= '0;
`ifdef UART_PARITY_EN
                par_err <= 1'b0;
`endif
            end

            if (state_q == S_DATA && tick) begin
                shift   <= {rx_s, shift[7:1]};
                bit_cnt <= bit_cnt + 3'd1;
            end

`ifdef UART_PARITY_EN
            // Even parity: the data bits and the parity bit hold an even number of ones.
            if (state_q == S_PARITY && tick) begin
                par_err <= ^{shift, rx_s};
            end
`endif
        end
    end

    // Word packing, address generation, timeout and completion.
    // NOTE: the lane buffer and byte count are reset like any other state, so
    // a reset mid-word discards the partial data instead of leaking it into
    // the next load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt     <= '0;
            word_buf     <= '0;
            next_addr    <= BASE_ADDR;
            word_written <= 1'b0;
            idle_cnt     <= '0;
            flush_pend   <= 1'b0;
            data_out     <= '0;
            addr_out     <= '0;
            wr_en        <= 1'b0;
            done         <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            wr_en      <= 1'b0;
            flush_pend <= 1'b0;

            if (stop_tick) begin
                if (byte_ok) begin
                    if (byte_cnt == 2'd3) begin
                        // The fourth byte goes straight onto the output word.
                        data_out     <= {shift, word_buf[23:0]};
                        addr_out     <= next_addr;
                        wr_en        <= 1'b1;
                        next_addr    <= next_addr + 32'd4;
                        byte_cnt     <= '0;
                        word_buf     <= '0;
                        word_written <= 1'b1;
                    end else begin
                        word_buf[{byte_cnt, 3'b000} +: 8] <= shift;
                        byte_cnt <= byte_cnt + 2'd1;
                    end
                end else begin
                    frame_err <= 1'b1;
                end
            end

            // The idle counter runs only in IDLE with the line high and
            // saturates, so the timeout acts at most once per idle stretch.
            if (state_q != S_IDLE || !rx_s) begin
                idle_cnt <= '0;
            end else if (idle_cnt != TO_MAX) begin
                idle_cnt <= idle_cnt + TW'(1);
            end

            if (timeout_fire) begin
                if (byte_cnt != 2'd0) begin
                    data_out     <= word_buf;
                    addr_out     <= next_addr;
                    wr_en        <= 1'b1;
                    next_addr    <= next_addr + 32'd4;
                    byte_cnt     <= '0;
                    word_buf     <= '0;
                    word_written <= 1'b1;
                    flush_pend   <= 1'b1;
                end else if (word_written) begin
                    done <= 1'b1;
                end
            end

            // After a flush, done follows on the next cycle.
            if (flush_pend) begin
                done <= 1'b1;
            end
        end
    end

endmodule
